// File: rtl/byte_pack_fifo.sv
// rtl/byte_pack_fifo.sv - byte-granular packing FIFO with variable-size writes and reads
// Storage is a packed byte vector with the oldest byte in the least significant lane.
module byte_pack_fifo #(
  parameter int LANES       = 4,
  parameter int DEPTH_BYTES = 32,
  parameter bit BYTE_SWAP   = 1'b1,
  localparam int CW = $clog2(LANES + 1),
  localparam int LW = $clog2(DEPTH_BYTES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [8*LANES-1:0] din,
  input  logic [CW-1:0]      din_bytes,
  input  logic               din_valid,
  output logic               din_ready,
  input  logic [CW-1:0]      rd_bytes,
  input  logic               rd_req,
  output logic [8*LANES-1:0] dout,
  output logic [CW-1:0]      dout_bytes,
  output logic               dout_valid,
  output logic [LW-1:0]      level,
  output logic               err_underrun,
  output logic               err_size
);

  localparam int MW = 8 * DEPTH_BYTES;
  localparam logic [CW-1:0] LANES_C = CW'(LANES);
  localparam logic [LW-1:0] RDY_MAX = LW'(DEPTH_BYTES - LANES);

  logic [MW-1:0]      mem_q, mem_n;
  logic [LW-1:0]      level_q, level_n;
  logic [8*LANES-1:0] wr_lsb, rd_word;
  logic               wr_ok, wr_size_bad, rd_size_bad, rd_short, rd_ok;
  int                 rd_n, wr_n, base;

  assign level       = level_q;
  assign din_ready   = (level_q <= RDY_MAX);
  assign wr_size_bad = din_valid && (din_bytes > LANES_C);
  assign wr_ok       = din_valid && din_ready && (din_bytes != '0) && !(din_bytes > LANES_C);
  assign rd_size_bad = rd_req && ((rd_bytes == '0) || (rd_bytes > LANES_C));
  assign rd_short    = rd_req && !rd_size_bad && (LW'(rd_bytes) > level_q);
  assign rd_ok       = rd_req && !rd_size_bad && !rd_short;

  always_comb begin
    rd_n    = rd_ok ? int'(rd_bytes) : 0;
    wr_n    = wr_ok ? int'(din_bytes) : 0;
    base    = int'(level_q) - rd_n;
    wr_lsb  = '0;
    rd_word = '0;
    // Normalise din to oldest-byte-first in lane 0, keeping only the valid bytes.
    for (int k = 0; k < LANES; k++) begin
      if (k < wr_n)
        wr_lsb[8*k +: 8] = BYTE_SWAP ? din[8*(LANES-1-k) +: 8] : din[8*k +: 8];
      if (k < rd_n) begin
        if (BYTE_SWAP)
          rd_word[8*(LANES-1-k) +: 8] = mem_q[8*k +: 8];
        else
          rd_word[8*k +: 8] = mem_q[8*k +: 8];
      end
    end
    // Bytes above level are always zero, so shift-then-OR merges cleanly.
    mem_n   = (mem_q >> (8 * rd_n)) | (MW'(wr_lsb) << (8 * base));
    level_n = LW'(base + wr_n);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q        <= '0;
      level_q      <= '0;
      dout         <= '0;
      dout_bytes   <= '0;
      dout_valid   <= 1'b0;
      err_underrun <= 1'b0;
      err_size     <= 1'b0;
    end else if (flush) begin
      mem_q        <= '0;
      level_q      <= '0;
      dout_valid   <= 1'b0;
      err_underrun <= 1'b0;
      err_size     <= 1'b0;
    end else begin
      mem_q        <= mem_n;
      level_q      <= level_n;
      dout_valid   <= rd_ok;
      err_underrun <= rd_short;
      err_size     <= rd_size_bad || wr_size_bad;
      if (rd_ok) begin
        dout       <= rd_word;
        dout_bytes <= rd_bytes;
      end
    end
  end

endmodule

// File: tb/tb_byte_pack_fifo.sv
// tb/tb_byte_pack_fifo.sv - directed vector bench for byte_pack_fifo
module tb_byte_pack_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-lane, 32-byte, MSB-first instance
  logic        rst4, flush4, din_valid4, din_ready4, rd_req4, dout_valid4, eu4, es4;
  logic [31:0] din4, dout4;
  logic [2:0]  din_bytes4, rd_bytes4, dout_bytes4;
  logic [5:0]  level4;

  // 8-lane, 64-byte, LSB-first instance
  logic        rst8, flush8, din_valid8, din_ready8, rd_req8, dout_valid8, eu8, es8;
  logic [63:0] din8, dout8;
  logic [3:0]  din_bytes8, rd_bytes8, dout_bytes8;
  logic [6:0]  level8;

  byte_pack_fifo #(.LANES(4), .DEPTH_BYTES(32), .BYTE_SWAP(1'b1)) dut (
    .clk(clk), .rst(rst4), .flush(flush4), .din(din4), .din_bytes(din_bytes4),
    .din_valid(din_valid4), .din_ready(din_ready4), .rd_bytes(rd_bytes4), .rd_req(rd_req4),
    .dout(dout4), .dout_bytes(dout_bytes4), .dout_valid(dout_valid4), .level(level4),
    .err_underrun(eu4), .err_size(es4));

  byte_pack_fifo #(.LANES(8), .DEPTH_BYTES(64), .BYTE_SWAP(1'b0)) dut8 (
    .clk(clk), .rst(rst8), .flush(flush8), .din(din8), .din_bytes(din_bytes8),
    .din_valid(din_valid8), .din_ready(din_ready8), .rd_bytes(rd_bytes8), .rd_req(rd_req8),
    .dout(dout8), .dout_bytes(dout_bytes8), .dout_valid(dout_valid8), .level(level8),
    .err_underrun(eu8), .err_size(es8));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst4) assert (level4 <= 6'd32) else $error("level4 out of range");
    if (!rst8) assert (level8 <= 7'd64) else $error("level8 out of range");
  end

  typedef struct {
    logic        flush;
    logic [31:0] din;
    logic [2:0]  db;
    logic        wv;
    logic [2:0]  rb;
    logic        rq;
    logic        e_dv;
    logic [31:0] e_dout;
    logic [2:0]  e_db;
    logic [5:0]  e_lvl;
    logic        e_rdy;
    logic        e_eu;
    logic        e_es;
  } vec_t;

  vec_t vq[$];

  task automatic drive4(input logic fl, input logic [31:0] d, input logic [2:0] db,
                        input logic wv, input logic [2:0] rb, input logic rq);
    @(negedge clk);
    flush4 = fl; din4 = d; din_bytes4 = db; din_valid4 = wv; rd_bytes4 = rb; rd_req4 = rq;
    @(posedge clk);
    #1;
  endtask

  task automatic check4(input string tag, input vec_t v);
    chk({tag, ".dout_valid"}, 64'(dout_valid4), 64'(v.e_dv));
    chk({tag, ".dout"}, 64'(dout4), 64'(v.e_dout));
    chk({tag, ".dout_bytes"}, 64'(dout_bytes4), 64'(v.e_db));
    chk({tag, ".level"}, 64'(level4), 64'(v.e_lvl));
    chk({tag, ".din_ready"}, 64'(din_ready4), 64'(v.e_rdy));
    chk({tag, ".err_underrun"}, 64'(eu4), 64'(v.e_eu));
    chk({tag, ".err_size"}, 64'(es4), 64'(v.e_es));
  endtask

  logic [7:0]  nb;
  logic [31:0] exp_word;
  vec_t        v;

  initial begin
    rst4 = 1'b1; flush4 = 0; din4 = '0; din_bytes4 = '0; din_valid4 = 0; rd_bytes4 = '0; rd_req4 = 0;
    rst8 = 1'b1; flush8 = 0; din8 = '0; din_bytes8 = '0; din_valid8 = 0; rd_bytes8 = '0; rd_req8 = 0;

    //            fl din           db wv rb rq  dv dout          db lvl rdy eu es
    vq.push_back('{0, 32'hAABBCCDD, 4, 1, 0, 0,  0, 32'h00000000, 0, 4, 1, 0, 0});
    vq.push_back('{0, 32'h00000000, 0, 0, 2, 1,  1, 32'hAABB0000, 2, 2, 1, 0, 0});
    vq.push_back('{0, 32'h00000000, 0, 0, 2, 1,  1, 32'hCCDD0000, 2, 0, 1, 0, 0});
    vq.push_back('{0, 32'h11EEEEEE, 1, 1, 0, 0,  0, 32'hCCDD0000, 2, 1, 1, 0, 0});
    vq.push_back('{0, 32'h2233EEEE, 2, 1, 0, 0,  0, 32'hCCDD0000, 2, 3, 1, 0, 0});
    vq.push_back('{0, 32'h445566EE, 3, 1, 0, 0,  0, 32'hCCDD0000, 2, 6, 1, 0, 0});
    vq.push_back('{0, 32'h00000000, 0, 0, 4, 1,  1, 32'h11223344, 4, 2, 1, 0, 0});
    vq.push_back('{0, 32'h00000000, 0, 0, 2, 1,  1, 32'h55660000, 2, 0, 1, 0, 0});
    vq.push_back('{0, 32'h010203EE, 3, 1, 0, 0,  0, 32'h55660000, 2, 3, 1, 0, 0});
    vq.push_back('{0, 32'hA1A2A3A4, 4, 1, 2, 1,  1, 32'h01020000, 2, 5, 1, 0, 0});
    vq.push_back('{0, 32'h00000000, 0, 0, 1, 1,  1, 32'h03000000, 1, 4, 1, 0, 0});
    vq.push_back('{0, 32'h00000000, 0, 0, 4, 1,  1, 32'hA1A2A3A4, 4, 0, 1, 0, 0});
    vq.push_back('{0, 32'hFFFFFFFF, 0, 1, 0, 0,  0, 32'hA1A2A3A4, 4, 0, 1, 0, 0});
    vq.push_back('{0, 32'h00000000, 0, 0, 0, 1,  0, 32'hA1A2A3A4, 4, 0, 1, 0, 1});
    vq.push_back('{0, 32'hCAFEBABE, 4, 1, 0, 0,  0, 32'hA1A2A3A4, 4, 4, 1, 0, 0});
    vq.push_back('{0, 32'h12345678, 5, 1, 0, 0,  0, 32'hA1A2A3A4, 4, 4, 1, 0, 1});
    vq.push_back('{0, 32'h00000000, 0, 0, 5, 1,  0, 32'hA1A2A3A4, 4, 4, 1, 0, 1});
    vq.push_back('{1, 32'h99999999, 4, 1, 2, 1,  0, 32'hA1A2A3A4, 4, 0, 1, 0, 0});
    vq.push_back('{0, 32'h00000000, 0, 0, 1, 1,  0, 32'hA1A2A3A4, 4, 0, 1, 1, 0});
    vq.push_back('{0, 32'h00000000, 0, 0, 0, 0,  0, 32'hA1A2A3A4, 4, 0, 1, 0, 0});

    // reset values while rst is held
    repeat (2) @(posedge clk);
    #1;
    v = '{0, 0, 0, 0, 0, 0,  0, 32'h0, 0, 0, 1, 0, 0};
    check4("reset", v);
    @(negedge clk);
    rst4 = 1'b0;

    foreach (vq[i]) begin
      drive4(vq[i].flush, vq[i].din, vq[i].db, vq[i].wv, vq[i].rb, vq[i].rq);
      check4($sformatf("vec%0d", i), vq[i]);
    end

    // fill with bytes 1..28, then one more byte to reach 29
    nb = 8'd1;
    for (int j = 0; j < 7; j++) begin
      drive4(0, {nb, nb + 8'd1, nb + 8'd2, nb + 8'd3}, 4, 1, 0, 0);
      nb = nb + 8'd4;
      chk($sformatf("fill%0d.level", j), 64'(level4), 64'(4 * (j + 1)));
    end
    chk("fill28.din_ready", 64'(din_ready4), 64'd1);
    drive4(0, {nb, 24'hEEEEEE}, 1, 1, 0, 0);
    chk("fill29.level", 64'(level4), 64'd29);
    chk("fill29.din_ready", 64'(din_ready4), 64'd0);
    drive4(0, 32'h77777777, 4, 1, 0, 0);
    chk("full_write.level", 64'(level4), 64'd29);
    chk("full_write.err_size", 64'(es4), 64'd0);

    nb = 8'd1;
    for (int j = 0; j < 7; j++) begin
      drive4(0, 0, 0, 0, 4, 1);
      exp_word = {nb, nb + 8'd1, nb + 8'd2, nb + 8'd3};
      nb = nb + 8'd4;
      chk($sformatf("drain%0d.dout", j), 64'(dout4), 64'(exp_word));
      chk($sformatf("drain%0d.dout_valid", j), 64'(dout_valid4), 64'd1);
    end
    chk("drain.level", 64'(level4), 64'd1);
    drive4(0, 0, 0, 0, 3, 1);
    chk("under.err_underrun", 64'(eu4), 64'd1);
    chk("under.dout_valid", 64'(dout_valid4), 64'd0);
    chk("under.level", 64'(level4), 64'd1);
    chk("under.dout_hold", 64'(dout4), 64'h191A1B1C);
    drive4(0, 0, 0, 0, 1, 1);
    chk("last.dout", 64'(dout4), 64'h1D000000);
    chk("last.dout_bytes", 64'(dout_bytes4), 64'd1);
    chk("last.level", 64'(level4), 64'd0);
    chk("last.err_underrun", 64'(eu4), 64'd0);

    // 8-lane LSB-first instance
    @(negedge clk);
    rst8 = 1'b0;
    din8 = 64'h0807060504030201; din_bytes8 = 4'd8; din_valid8 = 1'b1;
    @(posedge clk); #1;
    chk("l8.write.level", 64'(level8), 64'd8);
    @(negedge clk);
    din_valid8 = 1'b0; rd_bytes8 = 4'd3; rd_req8 = 1'b1;
    @(posedge clk); #1;
    chk("l8.read3.dout", dout8, 64'h0000000000030201);
    chk("l8.read3.dout_bytes", 64'(dout_bytes8), 64'd3);
    chk("l8.read3.level", 64'(level8), 64'd5);
    @(negedge clk);
    rd_bytes8 = 4'd2;
    @(posedge clk); #1;
    rd_req8 = 1'b0;
    chk("l8.read2.dout", dout8, 64'h0000000000000504);
    chk("l8.read2.dout_valid", 64'(dout_valid8), 64'd1);
    rst8 = 1'b1;
    #1;
    chk("l8.rst.dout_valid", 64'(dout_valid8), 64'd0);
    chk("l8.rst.dout", dout8, 64'd0);
    chk("l8.rst.dout_bytes", 64'(dout_bytes8), 64'd0);
    chk("l8.rst.level", 64'(level8), 64'd0);
    chk("l8.rst.din_ready", 64'(din_ready8), 64'd1);
    chk("l8.rst.errors", 64'({eu8, es8}), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
